// File: rtl/mx_blk_scale.sv
// Buffers one MX block of signed elements, derives the block's shared scale from
// the OR of all magnitudes, then replays the elements with a common shift.
module mx_blk_scale #(
    parameter int width_i     = 8,
    parameter int width_shift = 8,
    parameter int blk_size    = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [width_i-1:0]     i_num,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [width_i-1:0]     o_num,
    output logic [width_shift-1:0] o_shift,
    output logic [width_shift-1:0] o_scale,
    output logic                   o_zero,
    output logic                   o_first,
    output logic                   o_last
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and the producer holds data until taken.
    localparam int cnt_w = (blk_size > 1) ? $clog2(blk_size) : 1;
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(blk_size - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        CALC  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [cnt_w-1:0]       wr_cnt;
    logic [cnt_w-1:0]       rd_cnt;
    logic [width_i-1:0]     acc;
    logic [width_i-1:0]     mag;
    logic [width_i-1:0]     mem [blk_size];
    logic [width_shift-1:0] msb_pos;
    logic                   in_hs;
    logic                   out_hs;

    assign in_hs  = i_valid & o_ready;
    assign out_hs = o_valid & i_ready;

    // Unsigned magnitude: the most negative input maps to 2^(width_i-1) without saturating.
    always_comb begin
        mag = i_num[width_i-1] ? (~i_num + 1'b1) : i_num;
    end

    // The MSB of the OR of all magnitudes equals the MSB of the largest magnitude.
    always_comb begin
        msb_pos = '0;
        for (int i = 0; i < width_i; i++) begin
            if (acc[i]) msb_pos = width_shift'(i);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= FILL;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (in_hs && wr_cnt == cnt_last) state_nxt = CALC;
            CALC:    state_nxt = DRAIN;
            DRAIN:   if (out_hs && rd_cnt == cnt_last) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        o_ready = (state == FILL);
        o_valid = (state == DRAIN);
        o_first = o_valid && (rd_cnt == '0);
        o_last  = o_valid && (rd_cnt == cnt_last);
        o_num   = mem[rd_cnt];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            acc     <= '0;
            o_shift <= '0;
            o_scale <= '0;
            o_zero  <= 1'b0;
        end else begin
            if (in_hs) begin
                wr_cnt <= (wr_cnt == cnt_last) ? '0 : wr_cnt + 1'b1;
                acc    <= acc | mag;
            end
            if (state == CALC) begin
                o_scale <= msb_pos;
                o_shift <= width_shift'(width_i - 1) - msb_pos;
                o_zero  <= (acc == '0);
            end
            // Clearing acc on the final drain handshake keeps blocks independent.
            if (out_hs) begin
                if (rd_cnt == cnt_last) begin
                    rd_cnt <= '0;
                    acc    <= '0;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end
        end
    end

    // Element storage needs no reset: a discarded block is simply overwritten.
    always_ff @(posedge i_clk) begin
        if (in_hs) mem[wr_cnt] <= i_num;
    end

endmodule

// File: tb/tb_mx_blk_scale.sv
// Directed bench for mx_blk_scale with blk_size=4: a driver pushes hand-computed
// expectations, and an independent monitor pops them on each output handshake.
module tb_mx_blk_scale;

    localparam int W  = 8;
    localparam int WS = 8;
    localparam int EW = W + WS + WS + 3;

    logic          clk;
    logic          i_rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [W-1:0]  i_num;
    logic          o_valid;
    logic          i_ready;
    logic [W-1:0]  o_num;
    logic [WS-1:0] o_shift;
    logic [WS-1:0] o_scale;
    logic          o_zero;
    logic          o_first;
    logic          o_last;

    logic [EW-1:0] exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            acc_cyc = 0;
    logic          prev_valid = 1'b0;
    logic          stalled = 1'b0;
    logic [EW-1:0] held;
    logic [EW-1:0] act;

    mx_blk_scale #(.width_i(W), .width_shift(WS), .blk_size(4)) dut (
        .i_clk   (clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_num   (i_num),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_num   (o_num),
        .o_shift (o_shift),
        .o_scale (o_scale),
        .o_zero  (o_zero),
        .o_first (o_first),
        .o_last  (o_last)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, a, e, cyc);
        end
    endtask

    // Monitor: output word is {num, shift, scale, zero, first, last}.
    always @(negedge clk) begin
        act = {o_num, o_shift, o_scale, o_zero, o_first, o_last};
        if (!i_rst_n) begin
            prev_valid = 1'b0;
            stalled    = 1'b0;
        end else begin
            if (o_valid) begin
                if (!prev_valid) check("latency", cyc, acc_cyc + 2);
                check("ready_low_in_drain", {31'd0, o_ready}, 32'd0);
                if (stalled) check("hold_stable", act, held);
                if (i_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 32'd1, 32'd0);
                    end else begin
                        check("output", act, exp_q.pop_front());
                    end
                    stalled = 1'b0;
                end else begin
                    held    = act;
                    stalled = 1'b1;
                end
            end else begin
                stalled = 1'b0;
            end
            prev_valid = o_valid;
        end
    end

    task automatic put(input logic [W-1:0] v);
        bit ok;
        ok      = 1'b0;
        i_valid = 1'b1;
        i_num   = v;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (o_ready) begin
                ok      = 1'b1;
                acc_cyc = cyc;
                break;
            end
        end
        if (!ok) check("input_accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] c, input logic [W-1:0] d,
                              input logic [WS-1:0] scale, input logic [WS-1:0] shift,
                              input logic zero, input logic keep);
        logic [W-1:0] v [4];
        v = '{a, b, c, d};
        for (int k = 0; k < 4; k++)
            exp_q.push_back({v[k], shift, scale, zero, 1'(k == 0), 1'(k == 3)});
        for (int k = 0; k < 4; k++) put(v[k]);
        if (!keep) i_valid = 1'b0;
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (o_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("valid_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_empty();
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 32'd0);
    endtask

    logic pat [7];

    initial begin
        pat     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_num   = '0;
        i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_shift", {24'd0, o_shift}, 32'd0);
        check("rst_scale", {24'd0, o_scale}, 32'd0);
        check("rst_zero", {31'd0, o_zero}, 32'd0);
        i_rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Max magnitude 5 -> scale 2, shift 5.
        send_block(8'd3, -8'sd5, 8'd1, 8'd0, 8'd2, 8'd5, 1'b0, 1'b0);
        wait_empty();
        // -128 has magnitude 128 -> scale 7, shift 0.
        send_block(-8'sd128, 8'd1, 8'd2, 8'd4, 8'd7, 8'd0, 1'b0, 1'b0);
        wait_empty();
        // All-zero block.
        send_block(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd7, 1'b1, 1'b0);
        wait_empty();

        // Backpressure: OR of 10,20,30,40 = 62 -> scale 5, shift 2.
        i_ready = 1'b0;
        send_block(8'd10, -8'sd20, 8'd30, -8'sd40, 8'd5, 8'd2, 1'b0, 1'b0);
        wait_valid();
        @(posedge clk);
        #1;
        for (int k = 0; k < 7; k++) begin
            i_ready = pat[k];
            @(posedge clk);
            #1;
        end
        i_ready = 1'b1;
        check("ready_after_last", {31'd0, o_ready}, 32'd1);
        wait_empty();

        // i_valid held high over three blocks; each scale uses only its own elements.
        send_block(8'd100, 8'd2, 8'd3, 8'd4, 8'd6, 8'd1, 1'b0, 1'b1);
        send_block(8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd7, 1'b0, 1'b1);
        send_block(-8'sd9, 8'd5, 8'd0, 8'd16, 8'd4, 8'd3, 1'b0, 1'b0);
        wait_empty();

        // Reset after two drained outputs; the rest of the block is discarded.
        send_block(8'd5, -8'sd6, 8'd7, 8'd8, 8'd3, 8'd4, 1'b0, 1'b0);
        wait_valid();
        @(posedge clk);
        @(posedge clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        check("midreset_valid", {31'd0, o_valid}, 32'd0);
        check("midreset_queue_left", exp_q.size(), 32'd2);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        i_rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Fresh block: OR = 3 -> scale 1, shift 6; stale acc would give scale 3.
        send_block(8'd1, 8'd2, -8'sd3, 8'd0, 8'd1, 8'd6, 1'b0, 1'b0);
        wait_empty();
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
